// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with a start/done handshake: logic/arith ops complete in one cycle,
// shifts run 1 bit per cycle. Optional shift-add multiply on op 10 when ALU_MUL_EN is defined.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             err
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [3:0] OP_AND = 4'd0, OP_OR  = 4'd1, OP_ADD = 4'd2, OP_XOR = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4, OP_SRL = 4'd5, OP_SLL = 4'd6, OP_NOR = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8, OP_SLT = 4'd9;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd10;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef ALU_MUL_EN
        , MUL
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       kind_q, kind_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, carry_q, carry_d;
    logic             overflow_q, overflow_d, err_q, err_d, done_q, done_d;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_next;
`endif

    logic [WIDTH:0]   sum_ext, diff_ext;
    logic [WIDTH-1:0] shift_next, res_load;
    logic             carry_load, ovf_load, err_load, load_en;
    logic [SHW-1:0]   shamt;

    assign shamt    = b[SHW-1:0];
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    always_comb begin
        shift_next = {1'b0, work_q[WIDTH-1:1]};
        if (kind_q == OP_SLL)
            shift_next = {work_q[WIDTH-2:0], 1'b0};
        else if (kind_q == OP_SRA)
            shift_next = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
    end

`ifdef ALU_MUL_EN
    assign acc_next = work_q + (mplier_q[0] ? mcand_q : '0);
`endif

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        kind_d     = kind_q;
        result_d   = result_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        err_d      = err_q;
        done_d     = 1'b0;
        res_load   = '0;
        carry_load = 1'b0;
        ovf_load   = 1'b0;
        err_load   = 1'b0;
        load_en    = 1'b0;
`ifdef ALU_MUL_EN
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_en = 1'b1;
                    case (op)
                        OP_AND: res_load = a & b;
                        OP_OR:  res_load = a | b;
                        OP_XOR: res_load = a ^ b;
                        OP_NOR: res_load = ~(a | b);
                        OP_SLT: res_load = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
                        OP_ADD: begin
                            res_load   = sum_ext[WIDTH-1:0];
                            carry_load = sum_ext[WIDTH];
                            ovf_load   = (a[WIDTH-1] == b[WIDTH-1]) &&
                                         (sum_ext[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_SUB: begin
                            res_load   = diff_ext[WIDTH-1:0];
                            carry_load = diff_ext[WIDTH];
                            ovf_load   = (a[WIDTH-1] != b[WIDTH-1]) &&
                                         (diff_ext[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_SRL, OP_SLL, OP_SRA: begin
                            // A zero shift amount finishes immediately with a unchanged
                            res_load = a;
                            if (shamt != '0) begin
                                load_en = 1'b0;
                                work_d  = a;
                                cnt_d   = {1'b0, shamt};
                                kind_d  = op;
                                state_d = SHIFT;
                            end
                        end
`ifdef ALU_MUL_EN
                        OP_MUL: begin
                            load_en  = 1'b0;
                            work_d   = '0;
                            mcand_d  = a;
                            mplier_d = b;
                            cnt_d    = CW'(WIDTH);
                            state_d  = MUL;
                        end
`endif
                        default: err_load = 1'b1;
                    endcase
                end
            end
            SHIFT: begin
                work_d = shift_next;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    res_load = shift_next;
                    load_en  = 1'b1;
                    state_d  = IDLE;
                end
            end
`ifdef ALU_MUL_EN
            MUL: begin
                work_d   = acc_next;
                mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    res_load = acc_next;
                    load_en  = 1'b1;
                    state_d  = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (load_en) begin
            result_d   = res_load;
            zero_d     = (res_load == '0);
            carry_d    = carry_load;
            overflow_d = ovf_load;
            err_d      = err_load;
            done_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            work_q     <= '0;
            cnt_q      <= '0;
            kind_q     <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
`ifdef ALU_MUL_EN
            mcand_q    <= '0;
            mplier_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            kind_q     <= kind_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
            done_q     <= done_d;
`ifdef ALU_MUL_EN
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
`endif
        end
    end

    assign ready    = (state_q == IDLE);
    assign done     = done_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign overflow = overflow_q;
    assign err      = err_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Randomised and directed check of alu_multicycle against an arithmetic reference model.
module tb_alu_multicycle;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         ready, done, zero, carry, overflow, err;
    logic [W-1:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .ready(ready), .done(done), .result(result), .zero(zero),
        .carry(carry), .overflow(overflow), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z, c, v, e;
        logic [7:0]   lat;
    } exp_t;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   m;
        longint sx, sy, s;
        int     sh;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = int'(y % W);
        m = '0;
        m.lat = 8'd1;
        case (o)
            4'd0: m.r = x & y;
            4'd1: m.r = x | y;
            4'd2: begin
                m.r = x + y;
                m.c = ({32'd0, x} + {32'd0, y}) > 64'hFFFF_FFFF;
                s = sx + sy;
                m.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd3: m.r = x ^ y;
            4'd4: begin
                m.r = x - y;
                m.c = x < y;
                s = sx - sy;
                m.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd5: begin m.r = x >> sh; m.lat = 8'(sh + 1); end
            4'd6: begin m.r = x << sh; m.lat = 8'(sh + 1); end
            4'd7: m.r = ~(x | y);
            4'd8: begin m.r = W'($signed(x) >>> sh); m.lat = 8'(sh + 1); end
            4'd9: m.r = (sx < sy) ? 1 : 0;
`ifdef ALU_MUL_EN
            4'd10: begin m.r = W'(64'(x) * 64'(y)); m.lat = 8'(W + 1); end
`endif
            default: begin m.r = '0; m.e = 1'b1; end
        endcase
        m.z = (m.r == '0);
        return m;
    endfunction

    // Issues one op, optionally spraying ignored starts while busy, and checks the outcome.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit noise);
        exp_t         m;
        int           lat;
        logic [W-1:0] held;
        m = model(o, x, y);
        @(negedge clk);
        check_eq("ready_before_start", ready, 1'b1);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        lat = 1;
        start = 1'b0;
        while (!done) begin
            check_eq("busy_ready_low", ready, 1'b0);
            if (lat >= 60) begin
                check_eq("done_timeout", 1'b0, 1'b1);
                break;
            end
            if (noise) begin
                start = 1'($urandom);
                op = 4'($urandom); a = $urandom; b = $urandom;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        $display("op=%0d a=%h b=%h -> result=%h z=%0b c=%0b v=%0b e=%0b lat=%0d",
                 o, x, y, result, zero, carry, overflow, err, lat);
        check_eq("latency", 64'(lat), 64'(m.lat));
        check_eq("result", result, m.r);
        check_eq("zero", zero, m.z);
        check_eq("carry", carry, m.c);
        check_eq("overflow", overflow, m.v);
        check_eq("err", err, m.e);
        check_eq("ready_in_done", ready, 1'b1);
        held = result;
        @(posedge clk); #1;
        check_eq("done_single_pulse", done, 1'b0);
        check_eq("result_held", result, held);
    endtask

    initial begin
        logic [3:0] ro;
        logic [W-1:0] ra, rb;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("rst_result", result, '0);
        check_eq("rst_flags", {zero, carry, overflow, err, done}, 5'b0);
        check_eq("rst_ready", ready, 1'b1);

        run_op(4'd2, 32'h7FFF_FFFF, 32'd1, 1'b0);
        run_op(4'd4, 32'd5, 32'd7, 1'b0);
        run_op(4'd4, 32'd7, 32'd7, 1'b0);
        run_op(4'd8, 32'h8000_0000, 32'd4, 1'b1);
        run_op(4'd10, 32'h0001_0003, 32'd5, 1'b1);
        run_op(4'd12, 32'h1234, 32'h5678, 1'b0);
        run_op(4'd0, 32'hF0F0, 32'hFF00, 1'b0);

        // Back-to-back: second start presented in the done cycle of the first
        @(negedge clk);
        start = 1'b1; op = 4'd6; a = 32'h1234; b = 32'd0;
        @(posedge clk); #1;
        check_eq("b2b_first_done", done, 1'b1);
        check_eq("b2b_first_result", result, 32'h1234);
        op = 4'd2; a = 32'd2; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        $display("back-to-back SLL 0x1234<<0 then ADD 2+3 -> result=%h done=%0b", result, done);
        check_eq("b2b_second_done", done, 1'b1);
        check_eq("b2b_second_result", result, 32'd5);
        @(posedge clk); #1;
        check_eq("b2b_done_drop", done, 1'b0);

        // Reset while a long shift is in flight
        @(negedge clk);
        start = 1'b1; op = 4'd5; a = 32'hFFFF_FFFF; b = 32'd31;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check_eq("pre_reset_no_done", done, 1'b0);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        $display("reset mid-SRL -> result=%h ready=%0b done=%0b", result, ready, done);
        check_eq("abort_result", result, '0);
        check_eq("abort_ready", ready, 1'b1);
        check_eq("abort_flags", {zero, carry, overflow, err, done}, 5'b0);
        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #1;
            check_eq("abort_no_done", done, 1'b0);
        end

        for (int i = 0; i < 150; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: ra = 32'h7FFF_FFFF ^ 32'($urandom_range(0, 1) << 31);
                default: ;
            endcase
            run_op(ro, ra, rb, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
